// File: rtl/i2c_control_unit.sv
// i2c_control_unit: master-side sequencer for the I2C data unit.
// Generates SCL from a fractional tick accumulator (one tick per SCL half
// period) and walks one single-byte transaction:
// START, address+R/W, ACK, data byte, ACK/NACK, STOP.
// All outputs are registered and change only on clock edges.
module i2c_control_unit (
   input  logic        clock,
   input  logic        Reset,
   input  logic [19:0] BaudRate,
   input  logic [29:0] ClockFrequency,
   input  logic        Go,
   input  logic        Rw,
   input  logic [6:0]  Address,
   input  logic [7:0]  WriteData,
   input  logic        SDA,
   output logic        SCL,
   output logic [7:0]  SentData,
   output logic        WriteLoad,
   output logic        ReadorWrite,
   output logic        ShiftorHold,
   output logic        Select,
   output logic        StartStopAck,
   output logic        Busy,
   output logic        Done,
   output logic        AckError
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_ADDR, S_ACK1, S_DATA, S_ACK2, S_STOP
   } state_t;

   state_t      state_q, state_d;
   logic [29:0] acc_q, acc_d;
   logic [1:0]  ph_q, ph_d;       // half within a bit: 0 = L, 1 = H, 2 = STOP wrap-up
   logic [2:0]  bit_q, bit_d;
   logic [6:0]  addr_q, addr_d;
   logic        rw_q, rw_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        scl_q, scl_d;
   logic        ssa_q, ssa_d;
   logic        sel_q, sel_d;
   logic        row_q, row_d;
   logic [7:0]  sent_q, sent_d;
   logic        wl_q, wl_d;
   logic        sh_q, sh_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        ackerr_q, ackerr_d;

   logic [30:0] sum;
   logic        tick;

   // Tick generator: 31-bit sum so the threshold compare never wraps; the
   // 30-bit subtraction is exact because sum - ClockFrequency < 2^30.
   always_comb begin
      sum  = {1'b0, acc_q} + {10'd0, BaudRate, 1'b0};
      tick = (state_q != S_IDLE) && (sum >= {1'b0, ClockFrequency});
      if (state_q == S_IDLE)
         acc_d = '0;
      else if (tick)
         acc_d = sum[29:0] - ClockFrequency;
      else
         acc_d = sum[29:0];
   end

   // Transaction sequencer: next state and next value of every registered output.
   always_comb begin
      state_d  = state_q;
      ph_d     = ph_q;
      bit_d    = bit_q;
      addr_d   = addr_q;
      rw_d     = rw_q;
      wdata_d  = wdata_q;
      scl_d    = scl_q;
      ssa_d    = ssa_q;
      sel_d    = sel_q;
      row_d    = row_q;
      sent_d   = sent_q;
      wl_d     = 1'b0;
      sh_d     = 1'b0;
      busy_d   = busy_q;
      done_d   = 1'b0;
      ackerr_d = ackerr_q;

      case (state_q)
         S_IDLE: begin
            // Go during the Done clock is ignored so back-to-back transfers
            // always see at least one idle clock.
            if (Go && !done_q) begin
               addr_d   = Address;
               rw_d     = Rw;
               wdata_d  = WriteData;
               ackerr_d = 1'b0;
               busy_d   = 1'b1;
               ph_d     = 2'd0;
               bit_d    = 3'd0;
               scl_d    = 1'b1;
               ssa_d    = 1'b0;   // SDA falls while SCL is high
               sel_d    = 1'b0;
               state_d  = S_START;
            end
         end

         S_START: begin
            if (tick) begin
               scl_d = 1'b0;
               if (ph_q == 2'd0) begin
                  ph_d = 2'd1;
               end else begin
                  ph_d    = 2'd0;
                  bit_d   = 3'd0;
                  sent_d  = {addr_q, rw_q};
                  wl_d    = 1'b1;
                  row_d   = 1'b1;
                  sel_d   = 1'b1;
                  state_d = S_ADDR;
               end
            end
         end

         S_ADDR, S_DATA: begin
            if (tick) begin
               if (ph_q == 2'd0) begin
                  ph_d  = 2'd1;
                  scl_d = 1'b1;
               end else begin
                  // End of H half: shift/capture one bit, SCL falls.
                  ph_d  = 2'd0;
                  scl_d = 1'b0;
                  sh_d  = 1'b1;
                  if (bit_q == 3'd7) begin
                     bit_d   = 3'd0;
                     sel_d   = 1'b0;
                     ssa_d   = 1'b1;   // release SDA for the ACK slot
                     state_d = (state_q == S_ADDR) ? S_ACK1 : S_ACK2;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end
            end
         end

         S_ACK1: begin
            if (tick) begin
               if (ph_q == 2'd0) begin
                  ph_d  = 2'd1;
                  scl_d = 1'b1;
               end else begin
                  ph_d  = 2'd0;
                  scl_d = 1'b0;
                  if (SDA) begin
                     // No slave ACK on the address: skip straight to STOP.
                     ackerr_d = 1'b1;
                     ssa_d    = 1'b0;
                     row_d    = 1'b0;
                     state_d  = S_STOP;
                  end else if (!rw_q) begin
                     sent_d  = wdata_q;
                     wl_d    = 1'b1;
                     row_d   = 1'b1;
                     sel_d   = 1'b1;
                     state_d = S_DATA;
                  end else begin
                     // Read: keep SDA released, shift register captures.
                     row_d   = 1'b0;
                     sel_d   = 1'b0;
                     ssa_d   = 1'b1;
                     state_d = S_DATA;
                  end
               end
            end
         end

         S_ACK2: begin
            // On a read the master NACKs by keeping SDA released both halves.
            if (tick) begin
               if (ph_q == 2'd0) begin
                  ph_d  = 2'd1;
                  scl_d = 1'b1;
               end else begin
                  ph_d  = 2'd0;
                  scl_d = 1'b0;
                  if (!rw_q && SDA)
                     ackerr_d = 1'b1;
                  ssa_d   = 1'b0;
                  sel_d   = 1'b0;
                  row_d   = 1'b0;
                  state_d = S_STOP;
               end
            end
         end

         S_STOP: begin
            if (ph_q == 2'd2) begin
               // Wrap-up clock after the final tick; not tick-gated.
               ph_d    = 2'd0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (tick) begin
               if (ph_q == 2'd0) begin
                  ph_d  = 2'd1;
                  scl_d = 1'b1;
               end else begin
                  ph_d  = 2'd2;
                  ssa_d = 1'b1;   // SDA rises while SCL is high
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         ph_q     <= '0;
         bit_q    <= '0;
         addr_q   <= '0;
         rw_q     <= 1'b0;
         wdata_q  <= '0;
         scl_q    <= 1'b1;
         ssa_q    <= 1'b1;
         sel_q    <= 1'b0;
         row_q    <= 1'b0;
         sent_q   <= '0;
         wl_q     <= 1'b0;
         sh_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ackerr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         ph_q     <= ph_d;
         bit_q    <= bit_d;
         addr_q   <= addr_d;
         rw_q     <= rw_d;
         wdata_q  <= wdata_d;
         scl_q    <= scl_d;
         ssa_q    <= ssa_d;
         sel_q    <= sel_d;
         row_q    <= row_d;
         sent_q   <= sent_d;
         wl_q     <= wl_d;
         sh_q     <= sh_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ackerr_q <= ackerr_d;
      end
   end

   assign SCL          = scl_q;
   assign SentData     = sent_q;
   assign WriteLoad    = wl_q;
   assign ReadorWrite  = row_q;
   assign ShiftorHold  = sh_q;
   assign Select       = sel_q;
   assign StartStopAck = ssa_q;
   assign Busy         = busy_q;
   assign Done         = done_q;
   assign AckError     = ackerr_q;

endmodule
